// File: rtl/axi_qos_csr_slave.sv
// AXI4-Lite-style QoS configuration register block: holds M0/M1 QoS values, a
// set-only lock bit and a read-only ID word for one interconnect slave port.
module axi_qos_csr_slave #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [3:0]  M0_QOS_RST   = 4'd0,
  parameter logic [3:0]  M1_QOS_RST   = 4'd0,
  parameter logic [31:0] ID_VALUE     = 32'h0051_0501,
  parameter bit          REQUIRE_PRIV = 1'b0
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] S_AWADDR,
  input  logic [2:0]            S_AWPROT,
  input  logic                  S_AWVALID,
  output logic                  S_AWREADY,
  input  logic [31:0]           S_WDATA,
  input  logic [3:0]            S_WSTRB,
  input  logic                  S_WVALID,
  output logic                  S_WREADY,
  output logic [1:0]            S_BRESP,
  output logic                  S_BVALID,
  input  logic                  S_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_ARADDR,
  input  logic [2:0]            S_ARPROT,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  output logic [31:0]           S_RDATA,
  output logic [1:0]            S_RRESP,
  output logic                  S_RVALID,
  output logic                  S_RLAST,
  input  logic                  S_RREADY,
  output logic [3:0]            M0_QOS_CFG,
  output logic [3:0]            M1_QOS_CFG,
  output logic                  QOS_LOCKED,
  output logic                  QOS_UPDATE
);

  typedef enum logic [1:0] {
    REG_M0   = 2'd0,
    REG_M1   = 2'd1,
    REG_CTRL = 2'd2,
    REG_ID   = 2'd3
  } reg_sel_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // READY outputs stay low during reset and rise on the first edge after it.
  logic       rdy_en_q,     rdy_en_d;
  logic       aw_held_q,    aw_held_d;
  reg_sel_e   aw_sel_q,     aw_sel_d;
  logic       aw_priv_q,    aw_priv_d;
  logic       w_held_q,     w_held_d;
  logic [3:0] w_data_q,     w_data_d;
  logic       w_strb0_q,    w_strb0_d;
  logic       bvalid_q,     bvalid_d;
  logic [1:0] bresp_q,      bresp_d;
  logic       rvalid_q,     rvalid_d;
  logic [31:0] rdata_q,     rdata_d;
  logic [3:0] m0_qos_q,     m0_qos_d;
  logic [3:0] m1_qos_q,     m1_qos_d;
  logic       lock_q,       lock_d;
  logic       qos_update_q, qos_update_d;

  logic aw_hs, w_hs, ar_hs, commit;

  assign S_AWREADY = rdy_en_q && !aw_held_q && !bvalid_q;
  assign S_WREADY  = rdy_en_q && !w_held_q  && !bvalid_q;
  assign S_ARREADY = rdy_en_q && !rvalid_q;

  assign aw_hs  = S_AWVALID && S_AWREADY;
  assign w_hs   = S_WVALID  && S_WREADY;
  assign ar_hs  = S_ARVALID && S_ARREADY;
  assign commit = aw_held_q && w_held_q && !bvalid_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through this block can infer a latch.
    rdy_en_d     = 1'b1;
    aw_held_d    = aw_held_q;
    aw_sel_d     = aw_sel_q;
    aw_priv_d    = aw_priv_q;
    w_held_d     = w_held_q;
    w_data_d     = w_data_q;
    w_strb0_d    = w_strb0_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    m0_qos_d     = m0_qos_q;
    m1_qos_d     = m1_qos_q;
    lock_d       = lock_q;
    qos_update_d = 1'b0;

    if (bvalid_q && S_BREADY) bvalid_d = 1'b0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_sel_d  = reg_sel_e'(S_AWADDR[3:2]);
      aw_priv_d = S_AWPROT[0];
    end

    if (w_hs) begin
      w_held_d  = 1'b1;
      w_data_d  = S_WDATA[3:0];
      w_strb0_d = S_WSTRB[0];
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      if (REQUIRE_PRIV && !aw_priv_q) begin
        bresp_d = RESP_SLVERR;
      end else begin
        case (aw_sel_q)
          REG_M0, REG_M1: begin
            // The lock protects the QoS values; CTRL itself is set-only anyway.
            if (lock_q) begin
              bresp_d = RESP_SLVERR;
            end else if (w_strb0_q) begin
              if (aw_sel_q == REG_M0) m0_qos_d = w_data_q;
              else                    m1_qos_d = w_data_q;
              qos_update_d = 1'b1;
            end
          end
          REG_CTRL: if (w_strb0_q && w_data_q[0]) lock_d = 1'b1;
          default:  bresp_d = RESP_SLVERR;
        endcase
      end
    end

    if (rvalid_q && S_RREADY) rvalid_d = 1'b0;

    // Sampled from the current register values, so a same-edge write is not seen.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      case (reg_sel_e'(S_ARADDR[3:2]))
        REG_M0:   rdata_d = {28'd0, m0_qos_q};
        REG_M1:   rdata_d = {28'd0, m1_qos_q};
        REG_CTRL: rdata_d = {31'd0, lock_q};
        default:  rdata_d = ID_VALUE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_en_q     <= 1'b0;
      aw_held_q    <= 1'b0;
      aw_sel_q     <= REG_M0;
      aw_priv_q    <= 1'b0;
      w_held_q     <= 1'b0;
      w_data_q     <= 4'd0;
      w_strb0_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      m0_qos_q     <= M0_QOS_RST;
      m1_qos_q     <= M1_QOS_RST;
      lock_q       <= 1'b0;
      qos_update_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values,
      // which is what gives reads the old value on a colliding write.
      rdy_en_q     <= rdy_en_d;
      aw_held_q    <= aw_held_d;
      aw_sel_q     <= aw_sel_d;
      aw_priv_q    <= aw_priv_d;
      w_held_q     <= w_held_d;
      w_data_q     <= w_data_d;
      w_strb0_q    <= w_strb0_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      m0_qos_q     <= m0_qos_d;
      m1_qos_q     <= m1_qos_d;
      lock_q       <= lock_d;
      qos_update_q <= qos_update_d;
    end
  end

  assign S_BVALID   = bvalid_q;
  assign S_BRESP    = bresp_q;
  assign S_RVALID   = rvalid_q;
  assign S_RLAST    = rvalid_q;
  assign S_RDATA    = rdata_q;
  assign S_RRESP    = RESP_OKAY;
  assign M0_QOS_CFG = m0_qos_q;
  assign M1_QOS_CFG = m1_qos_q;
  assign QOS_LOCKED = lock_q;
  assign QOS_UPDATE = qos_update_q;

  // Address bits outside [3:2], upper data/strobe bits and ARPROT are don't-care.
  logic unused_inputs;
  assign unused_inputs = ^{S_AWADDR, S_ARADDR, S_AWPROT, S_ARPROT, S_WDATA, S_WSTRB};

endmodule

// File: tb/tb_axi_qos_csr_slave.sv
// Directed bench for axi_qos_csr_slave: inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_axi_qos_csr_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] S_AWADDR, S_ARADDR, S_WDATA, S_RDATA;
  logic [2:0]  S_AWPROT, S_ARPROT;
  logic [3:0]  S_WSTRB, M0_QOS_CFG, M1_QOS_CFG;
  logic [1:0]  S_BRESP, S_RRESP;
  logic        S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
  logic        S_ARVALID, S_ARREADY, S_RVALID, S_RLAST, S_RREADY;
  logic        QOS_LOCKED, QOS_UPDATE;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_qos_csr_slave #(.REQUIRE_PRIV(1'b1)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RLAST(S_RLAST),
    .S_RREADY(S_RREADY),
    .M0_QOS_CFG(M0_QOS_CFG), .M1_QOS_CFG(M1_QOS_CFG),
    .QOS_LOCKED(QOS_LOCKED), .QOS_UPDATE(QOS_UPDATE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // AW and W presented together; returns BRESP and how many cycles QOS_UPDATE was high.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot,
                          output logic [1:0] resp, output int upd);
    int   n;
    logic aw_hs, w_hs;
    @(negedge clk);
    S_AWADDR = addr; S_AWPROT = prot; S_AWVALID = 1'b1;
    S_WDATA  = data; S_WSTRB  = strb; S_WVALID  = 1'b1;
    S_BREADY = 1'b0;
    n = 0; upd = 0;
    while ((S_AWVALID || S_WVALID) && n < 20) begin
      aw_hs = S_AWVALID && S_AWREADY;
      w_hs  = S_WVALID && S_WREADY;
      @(negedge clk);
      n++;
      if (aw_hs) S_AWVALID = 1'b0;
      if (w_hs)  S_WVALID  = 1'b0;
    end
    while (!S_BVALID && n < 40) begin
      upd += int'(QOS_UPDATE);
      @(negedge clk);
      n++;
    end
    check("wr_bvalid", S_BVALID, 1);
    upd += int'(QOS_UPDATE);
    resp = S_BRESP;
    S_BREADY = 1'b1;
    @(negedge clk);
    upd += int'(QOS_UPDATE);
    check("wr_bvalid_clr", S_BVALID, 0);
    S_AWVALID = 1'b0; S_WVALID = 1'b0; S_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output logic last);
    int n;
    @(negedge clk);
    S_ARADDR = addr; S_ARVALID = 1'b1; S_RREADY = 1'b0;
    n = 0;
    while (!S_ARREADY && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    S_ARVALID = 1'b0;
    check("rd_rvalid", S_RVALID, 1);
    data = S_RDATA; resp = S_RRESP; last = S_RLAST;
    S_RREADY = 1'b1;
    @(negedge clk);
    check("rd_rvalid_clr", S_RVALID, 0);
    S_RREADY = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  resp;
    logic        last;
    int          upd;

    rst_n = 1'b0;
    S_AWADDR = '0; S_AWPROT = '0; S_AWVALID = 1'b0;
    S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0; S_BREADY = 1'b0;
    S_ARADDR = '0; S_ARPROT = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_m0", M0_QOS_CFG, 0);
    check("rst_m1", M1_QOS_CFG, 0);
    check("rst_lock", QOS_LOCKED, 0);
    check("rst_valids", {S_BVALID, S_RVALID, QOS_UPDATE}, 0);
    check("rst_readys", {S_AWREADY, S_WREADY, S_ARREADY}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_readys", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);

    do_read(32'hC, rd, resp, last);
    check("id_data", rd, 32'h0051_0501);
    check("id_resp", resp, 0);
    check("id_last", last, 1);

    // Write 0x0 = 12 with AW and W together: BVALID after two edges
    @(negedge clk);
    S_AWADDR = 32'h0; S_AWPROT = 3'b001; S_AWVALID = 1'b1;
    S_WDATA = 32'd12; S_WSTRB = 4'hF; S_WVALID = 1'b1; S_BREADY = 1'b0;
    @(negedge clk);
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    check("lat_bvalid_e1", S_BVALID, 0);
    @(negedge clk);
    check("lat_bvalid_e2", S_BVALID, 1);
    check("lat_bresp", S_BRESP, 0);
    check("lat_update", QOS_UPDATE, 1);
    check("lat_m0", M0_QOS_CFG, 12);
    S_BREADY = 1'b1;
    @(negedge clk);
    check("lat_bvalid_clr", S_BVALID, 0);
    check("lat_update_clr", QOS_UPDATE, 0);
    S_BREADY = 1'b0;
    do_read(32'h0, rd, resp, last);
    check("rd_m0", rd, 32'h0000_000C);

    // W three cycles before AW, then BREADY held low for four cycles
    @(negedge clk);
    S_WDATA = 32'd2; S_WSTRB = 4'hF; S_WVALID = 1'b1;
    @(negedge clk);
    S_WVALID = 1'b0;
    check("w_early_wready", S_WREADY, 0);
    repeat (2) @(negedge clk);
    S_AWADDR = 32'h4; S_AWPROT = 3'b001; S_AWVALID = 1'b1;
    @(negedge clk);
    S_AWVALID = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("bhold_bvalid", S_BVALID, 1);
      check("bhold_bresp", S_BRESP, 0);
      check("bhold_readys", {S_AWREADY, S_WREADY}, 0);
      @(negedge clk);
    end
    check("m1_after_write", M1_QOS_CFG, 2);
    S_BREADY = 1'b1;
    @(negedge clk);
    check("bhold_clr", S_BVALID, 0);
    S_BREADY = 1'b0;

    // Strobe-less write: OKAY, no change, no update pulse
    do_write(32'h0, 32'd5, 4'h0, 3'b001, resp, upd);
    check("nostrb_resp", resp, 2'b00);
    check("nostrb_m0", M0_QOS_CFG, 12);
    check("nostrb_upd", upd, 0);

    // Unprivileged write rejected
    do_write(32'h4, 32'd9, 4'hF, 3'b000, resp, upd);
    check("priv_resp", resp, 2'b10);
    check("priv_m1", M1_QOS_CFG, 2);
    check("priv_upd", upd, 0);

    do_write(32'hC, 32'hFFFF_FFFF, 4'hF, 3'b001, resp, upd);
    check("id_wr_resp", resp, 2'b10);

    // Updating write through the task: exactly one QOS_UPDATE cycle
    do_write(32'h4, 32'd3, 4'hF, 3'b001, resp, upd);
    check("m1_wr_resp", resp, 2'b00);
    check("m1_wr_upd", upd, 1);

    // Read and write commit on the same edge of M1: read sees the old value
    @(negedge clk);
    S_AWADDR = 32'h4; S_AWPROT = 3'b001; S_AWVALID = 1'b1;
    S_WDATA = 32'd7; S_WSTRB = 4'h1; S_WVALID = 1'b1; S_BREADY = 1'b1;
    @(negedge clk);
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    S_ARADDR = 32'h4; S_ARVALID = 1'b1; S_RREADY = 1'b0;
    @(negedge clk);
    S_ARVALID = 1'b0;
    check("coll_rvalid", S_RVALID, 1);
    check("coll_rdata", S_RDATA, 3);
    check("coll_m1", M1_QOS_CFG, 7);
    S_RREADY = 1'b1;
    @(negedge clk);
    check("coll_rclr", {S_RVALID, S_BVALID}, 0);
    S_RREADY = 1'b0; S_BREADY = 1'b0;

    // Lock, then QoS writes are refused and the lock cannot be cleared
    do_write(32'h8, 32'd1, 4'hF, 3'b001, resp, upd);
    check("lock_resp", resp, 2'b00);
    check("lock_set", QOS_LOCKED, 1);
    do_write(32'h0, 32'd15, 4'hF, 3'b001, resp, upd);
    check("locked_resp", resp, 2'b10);
    check("locked_m0", M0_QOS_CFG, 12);
    check("locked_upd", upd, 0);
    do_write(32'h8, 32'd0, 4'hF, 3'b001, resp, upd);
    check("lock_sticky", QOS_LOCKED, 1);
    do_read(32'h8, rd, resp, last);
    check("rd_ctrl", rd, 1);

    // Reset while AW is held and RVALID is up
    @(negedge clk);
    S_AWADDR = 32'h0; S_AWPROT = 3'b001; S_AWVALID = 1'b1;
    @(negedge clk);
    S_AWVALID = 1'b0;
    check("aw_held_ready", S_AWREADY, 0);
    S_ARADDR = 32'hC; S_ARVALID = 1'b1; S_RREADY = 1'b0;
    @(negedge clk);
    S_ARVALID = 1'b0;
    check("pre_rst_rvalid", S_RVALID, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rvalid", {S_RVALID, S_RLAST, S_BVALID, QOS_UPDATE}, 0);
    check("async_rdata", S_RDATA, 0);
    check("async_readys", {S_AWREADY, S_WREADY, S_ARREADY}, 0);
    check("async_regs", {M0_QOS_CFG, M1_QOS_CFG, 3'b000, QOS_LOCKED}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    S_WDATA = 32'd3; S_WSTRB = 4'hF; S_WVALID = 1'b1; S_BREADY = 1'b0;
    @(negedge clk);
    S_WVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("no_stray_bvalid", S_BVALID, 0);
      @(negedge clk);
    end
    check("post_rst_m0", M0_QOS_CFG, 0);
    check("post_rst_awready", S_AWREADY, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
